// File: rtl/vend_item_table_mc_if.sv
// APB configuration port plus per-channel dispense and lookup signals of the
// vending item table.
//   master : APB requester and vending FSMs (drive requests, receive results)
//   slave  : item table (receives requests, drives prdata/pready/pslverr,
//            disp_ack/disp_ok and lkp_price/lkp_stock)
interface vend_item_table_mc_if #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned ID_W    = 6,
  parameter int unsigned PRICE_W = 16,
  parameter int unsigned STOCK_W = 8,
  parameter int unsigned NUM_CH  = 2
);
  // APB
  logic [ADDR_W-1:0]          paddr;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [31:0]                pwdata;
  logic [31:0]                prdata;
  logic                       pready;
  logic                       pslverr;
  // Dispense channels
  logic [NUM_CH-1:0]          disp_req;
  logic [NUM_CH*ID_W-1:0]     disp_id;
  logic [NUM_CH*STOCK_W-1:0]  disp_qty;
  logic [NUM_CH-1:0]          disp_ack;
  logic [NUM_CH-1:0]          disp_ok;
  // Lookup channels
  logic [NUM_CH*ID_W-1:0]     lkp_id;
  logic [NUM_CH*PRICE_W-1:0]  lkp_price;
  logic [NUM_CH*STOCK_W-1:0]  lkp_stock;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    output disp_req, disp_id, disp_qty, lkp_id,
    input  prdata, pready, pslverr, disp_ack, disp_ok, lkp_price, lkp_stock
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    input  disp_req, disp_id, disp_qty, lkp_id,
    output prdata, pready, pslverr, disp_ack, disp_ok, lkp_price, lkp_stock
  );
endinterface

// File: rtl/vend_item_table_mc.sv
// Vending item table: per-item price/stock/dispensed-count storage configured
// over APB (one wait state per transfer) and consumed by NUM_CH dispense
// channels with fixed-priority arbitration and registered lookup ports.
// Ports:
//   pclk  : clock
//   prstn : asynchronous active-low reset
//   bus   : vend_item_table_mc_if.slave (APB, dispense and lookup signals)
module vend_item_table_mc #(
  parameter int unsigned MAX_ITEMS = 64,
  parameter int unsigned ID_W      = $clog2(MAX_ITEMS),
  parameter int unsigned PRICE_W   = 16,
  parameter int unsigned STOCK_W   = 8,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                 pclk,
  input  logic                 prstn,
  vend_item_table_mc_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned ADDR_CTRL = 32'h000;
  localparam int unsigned ADDR_STAT = 32'h004;
  localparam int unsigned ITEM_BASE = 32'h100;
  localparam int unsigned ITEM_END  = ITEM_BASE + 4 * MAX_ITEMS;
  localparam int unsigned TOT_W     = 16;

  logic [1:0]                 state_q, state_d;
  logic [31:0]                prdata_q, prdata_d;
  logic                       pready_q, pready_d;
  logic                       pslverr_q, pslverr_d;

  logic [PRICE_W-1:0]         price_q [MAX_ITEMS];
  logic [PRICE_W-1:0]         price_d [MAX_ITEMS];
  logic [STOCK_W-1:0]         stock_q [MAX_ITEMS];
  logic [STOCK_W-1:0]         stock_d [MAX_ITEMS];
  logic [STOCK_W-1:0]         cnt_q   [MAX_ITEMS];
  logic [STOCK_W-1:0]         cnt_d   [MAX_ITEMS];

  logic [ID_W-1:0]            num_items_q, num_items_d;
  logic                       lock_q, lock_d;
  logic [TOT_W-1:0]           total_q, total_d;
  logic                       err_q, err_d;

  logic [NUM_CH-1:0]          ack_q, ack_d;
  logic [NUM_CH-1:0]          ok_q, ok_d;
  logic [NUM_CH*PRICE_W-1:0]  lkp_price_q, lkp_price_d;
  logic [NUM_CH*STOCK_W-1:0]  lkp_stock_q, lkp_stock_d;

  // Address decode
  logic [31:0]                addr32;
  logic                       hit_ctrl, hit_stat, hit_item;
  logic [ID_W-1:0]            item_idx;

  logic                       unused_pwdata;
  assign unused_pwdata = ^bus.pwdata;

  always_comb begin
    addr32   = 32'(bus.paddr);
    hit_ctrl = (addr32 == ADDR_CTRL);
    hit_stat = (addr32 == ADDR_STAT);
    hit_item = (addr32 >= ITEM_BASE) && (addr32 < ITEM_END) && (addr32[1:0] == 2'b00);
    item_idx = ID_W'((addr32 - ITEM_BASE) >> 2);
  end

  // APB FSM, register commits and dispense arbitration
  logic [31:0]                rd_word;
  logic                       item_wr;
  logic                       granted;
  logic [ID_W-1:0]            g_id;
  logic [STOCK_W-1:0]         g_qty;
  logic                       g_ok;
  logic [STOCK_W:0]           cnt_sum;

  always_comb begin
    state_d     = state_q;
    prdata_d    = prdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    price_d     = price_q;
    stock_d     = stock_q;
    cnt_d       = cnt_q;
    num_items_d = num_items_q;
    lock_d      = lock_q;
    total_d     = total_q;
    err_d       = err_q;
    ack_d       = '0;
    ok_d        = '0;
    rd_word     = '0;
    item_wr     = 1'b0;
    granted     = 1'b0;
    g_id        = '0;
    g_qty       = '0;
    g_ok        = 1'b0;
    cnt_sum     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.psel && bus.penable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          // Transfer abandoned: nothing commits
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
          if (hit_ctrl) begin
            rd_word[31]       = lock_q;
            rd_word[ID_W-1:0] = num_items_q;
            if (bus.pwrite) begin
              num_items_d = bus.pwdata[ID_W-1:0];
              lock_d      = bus.pwdata[31];
            end
          end else if (hit_stat) begin
            rd_word[TOT_W-1:0] = total_q;
            rd_word[16]        = err_q;
            if (bus.pwrite) begin
              if (bus.pwdata[16]) err_d   = 1'b0;
              if (bus.pwdata[31]) total_d = '0;
            end
          end else if (hit_item) begin
            rd_word[PRICE_W-1:0]   = price_q[item_idx];
            rd_word[16 +: STOCK_W] = stock_q[item_idx];
            rd_word[24 +: STOCK_W] = cnt_q[item_idx];
            if (bus.pwrite) begin
              if (!lock_q) begin
                pslverr_d = 1'b1;
              end else begin
                item_wr           = 1'b1;
                price_d[item_idx] = bus.pwdata[PRICE_W-1:0];
                stock_d[item_idx] = bus.pwdata[16 +: STOCK_W];
                cnt_d[item_idx]   = '0;
              end
            end
          end else begin
            pslverr_d = 1'b1;
          end
          if (!bus.pwrite) prdata_d = rd_word;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Lowest-index eligible channel wins; applied after the APB commit so a
    // same-edge error set or counter increment is not lost to a clear.
    for (int c = 0; c < NUM_CH; c++) begin
      if (!granted && bus.disp_req[c] && !ack_q[c] && !lock_q && !item_wr) begin
        granted = 1'b1;
        g_id    = bus.disp_id[c*ID_W +: ID_W];
        g_qty   = bus.disp_qty[c*STOCK_W +: STOCK_W];
        g_ok    = (g_id < num_items_q) && (32'(g_id) < MAX_ITEMS) &&
                  (g_qty != '0) && (g_qty <= stock_q[g_id]);
        ack_d[c] = 1'b1;
        ok_d[c]  = g_ok;
        if (g_ok) begin
          stock_d[g_id] = stock_q[g_id] - g_qty;
          cnt_sum       = {1'b0, cnt_q[g_id]} + {1'b0, g_qty};
          cnt_d[g_id]   = cnt_sum[STOCK_W] ? '1 : cnt_sum[STOCK_W-1:0];
          if (total_d != '1) total_d = total_d + TOT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Lookup ports read pre-edge table contents
  logic [ID_W-1:0] l_id;

  always_comb begin
    lkp_price_d = '0;
    lkp_stock_d = '0;
    l_id        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      l_id = bus.lkp_id[c*ID_W +: ID_W];
      if ((l_id < num_items_q) && (32'(l_id) < MAX_ITEMS)) begin
        lkp_price_d[c*PRICE_W +: PRICE_W] = price_q[l_id];
        lkp_stock_d[c*STOCK_W +: STOCK_W] = stock_q[l_id];
      end
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q     <= ST_IDLE;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      for (int i = 0; i < MAX_ITEMS; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      num_items_q <= '0;
      lock_q      <= 1'b1;
      total_q     <= '0;
      err_q       <= 1'b0;
      ack_q       <= '0;
      ok_q        <= '0;
      lkp_price_q <= '0;
      lkp_stock_q <= '0;
    end else begin
      state_q     <= state_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      price_q     <= price_d;
      stock_q     <= stock_d;
      cnt_q       <= cnt_d;
      num_items_q <= num_items_d;
      lock_q      <= lock_d;
      total_q     <= total_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      ok_q        <= ok_d;
      lkp_price_q <= lkp_price_d;
      lkp_stock_q <= lkp_stock_d;
    end
  end

  assign bus.prdata    = prdata_q;
  assign bus.pready    = pready_q;
  assign bus.pslverr   = pslverr_q;
  assign bus.disp_ack  = ack_q;
  assign bus.disp_ok   = ok_q;
  assign bus.lkp_price = lkp_price_q;
  assign bus.lkp_stock = lkp_stock_q;

endmodule

// File: tb/tb_vend_item_table_mc.sv
// Scoreboard bench for vend_item_table_mc: stimulus pushes expected APB
// responses and dispense results (from a behavioural item-table model) into
// queues; a negedge monitor pops and compares whenever pready or disp_ack is seen.
`timescale 1ns/1ps
module tb_vend_item_table_mc;

  localparam int unsigned MAX_ITEMS = 64;
  localparam int unsigned ID_W      = 6;
  localparam int unsigned PRICE_W   = 16;
  localparam int unsigned STOCK_W   = 8;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned ADDR_W    = 12;

  logic pclk  = 1'b0;
  logic prstn = 1'b0;
  always #5 pclk = ~pclk;

  vend_item_table_mc_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .PRICE_W(PRICE_W),
                          .STOCK_W(STOCK_W), .NUM_CH(NUM_CH)) ifc ();

  vend_item_table_mc #(.MAX_ITEMS(MAX_ITEMS), .ID_W(ID_W), .PRICE_W(PRICE_W),
                       .STOCK_W(STOCK_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .pclk  (pclk),
    .prstn (prstn),
    .bus   (ifc.slave)
  );

  typedef struct { bit is_read; logic [31:0] data; bit err; } apb_exp_t;
  typedef struct { int ch; bit ok; } disp_exp_t;

  apb_exp_t  apb_q[$];
  disp_exp_t disp_q[$];
  apb_exp_t  me;
  disp_exp_t md;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the table
  int unsigned m_price [MAX_ITEMS];
  int unsigned m_stock [MAX_ITEMS];
  int unsigned m_cnt   [MAX_ITEMS];
  int unsigned m_num;
  int unsigned m_total;
  bit          m_lock;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < int'(MAX_ITEMS); i++) begin
      m_price[i] = 0; m_stock[i] = 0; m_cnt[i] = 0;
    end
    m_num = 0; m_total = 0; m_lock = 1'b1; m_err = 1'b0;
  endfunction

  function automatic bit m_is_item(input logic [31:0] a);
    return (a >= 32'h100) && (a < 32'h100 + 4 * MAX_ITEMS) && (a % 4 == 0);
  endfunction

  function automatic bit m_write(input logic [31:0] a, input logic [31:0] d);
    int unsigned n;
    n = (a - 32'h100) / 4;
    if (a == 32'h0) begin
      m_num  = d % (2 ** ID_W);
      m_lock = d[31];
      return 1'b0;
    end else if (a == 32'h4) begin
      if (d[16]) m_err = 1'b0;
      if (d[31]) m_total = 0;
      return 1'b0;
    end else if (m_is_item(a)) begin
      if (!m_lock) return 1'b1;
      m_price[n] = d % 65536;
      m_stock[n] = (d / 65536) % 256;
      m_cnt[n]   = 0;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit err);
    int unsigned n;
    n   = (a - 32'h100) / 4;
    err = 1'b0;
    if (a == 32'h0)  return (m_lock ? 32'h8000_0000 : 32'h0) + m_num;
    if (a == 32'h4)  return (m_err ? 32'h0001_0000 : 32'h0) + m_total;
    if (m_is_item(a)) return m_cnt[n] * 32'h0100_0000 + m_stock[n] * 32'h1_0000 + m_price[n];
    err = 1'b1;
    return 32'h0;
  endfunction

  function automatic bit m_disp(input int unsigned id, input int unsigned qty);
    bit ok;
    ok = (id < m_num) && (id < MAX_ITEMS) && (qty != 0) && (qty <= m_stock[id]);
    if (ok) begin
      m_stock[id] = m_stock[id] - qty;
      m_cnt[id]   = (m_cnt[id] + qty > 255) ? 255 : m_cnt[id] + qty;
      if (m_total < 65535) m_total++;
    end else begin
      m_err = 1'b1;
    end
    return ok;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge pclk) begin
    if (prstn) begin
      if (ifc.pready) begin
        if (apb_q.size() == 0) chk("apb_unexpected_pready", 32'(ifc.pready), 32'd0);
        else begin
          me = apb_q.pop_front();
          chk("pslverr", 32'(ifc.pslverr), 32'(me.err));
          if (me.is_read) chk("prdata", ifc.prdata, me.data);
        end
      end
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (ifc.disp_ack[c]) begin
          if (disp_q.size() == 0) chk("disp_unexpected_ack", 32'(ifc.disp_ack[c]), 32'd0);
          else begin
            md = disp_q.pop_front();
            chk("disp_channel", 32'(c), 32'(md.ch));
            chk("disp_ok", 32'(ifc.disp_ok[c]), 32'(md.ok));
          end
        end
      end
    end
  end

  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
    apb_exp_t e;
    bit       rerr;
    int       k;
    e.is_read = !wr;
    e.data    = '0;
    if (wr) e.err = m_write(a, d);
    else begin
      e.data = m_read(a, rerr);
      e.err  = rerr;
    end
    apb_q.push_back(e);
    @(negedge pclk);
    ifc.paddr = ADDR_W'(a); ifc.pwrite = wr; ifc.pwdata = d;
    ifc.psel = 1'b1; ifc.penable = 1'b0;
    @(negedge pclk);
    ifc.penable = 1'b1;
    k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (!ifc.pready && k < 10);
    if (!ifc.pready) begin
      chk("apb_pready_seen", 32'(ifc.pready), 32'd1);
      void'(apb_q.pop_back());
    end else begin
      chk("apb_latency", 32'(k), 32'd2);
    end
    ifc.psel = 1'b0; ifc.penable = 1'b0; ifc.pwrite = 1'b0;
  endtask

  task automatic set_ch(input int c, input int unsigned id, input int unsigned qty);
    ifc.disp_id[c*ID_W +: ID_W]        = ID_W'(id);
    ifc.disp_qty[c*STOCK_W +: STOCK_W] = STOCK_W'(qty);
  endtask

  // Wait for the ack of an already-raised request whose expectation is queued
  task automatic wait_ack(input int c, input int exp_lat);
    int k;
    k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (!ifc.disp_ack[c] && k < 20);
    chk("disp_ack_seen", 32'(ifc.disp_ack[c]), 32'd1);
    if (ifc.disp_ack[c]) chk("disp_latency", 32'(k), 32'(exp_lat));
    else void'(disp_q.pop_back());
    ifc.disp_req[c] = 1'b0;
  endtask

  task automatic disp_one(input int c, input int unsigned id, input int unsigned qty);
    disp_exp_t e;
    e.ch = c;
    e.ok = m_disp(id, qty);
    disp_q.push_back(e);
    @(negedge pclk);
    set_ch(c, id, qty);
    ifc.disp_req[c] = 1'b1;
    wait_ack(c, 1);
  endtask

  task automatic disp_two(input int unsigned id0, input int unsigned q0,
                          input int unsigned id1, input int unsigned q1);
    disp_exp_t e;
    int k, lat0, lat1;
    e.ch = 0; e.ok = m_disp(id0, q0); disp_q.push_back(e);
    e.ch = 1; e.ok = m_disp(id1, q1); disp_q.push_back(e);
    @(negedge pclk);
    set_ch(0, id0, q0);
    set_ch(1, id1, q1);
    ifc.disp_req = 2'b11;
    k = 0; lat0 = 0; lat1 = 0;
    while ((lat0 == 0 || lat1 == 0) && k < 20) begin
      @(negedge pclk);
      k++;
      if (ifc.disp_ack[0] && lat0 == 0) begin lat0 = k; ifc.disp_req[0] = 1'b0; end
      if (ifc.disp_ack[1] && lat1 == 0) begin lat1 = k; ifc.disp_req[1] = 1'b0; end
    end
    chk("dual_latency_ch0", 32'(lat0), 32'd1);
    chk("dual_latency_ch1", 32'(lat1), 32'd2);
    ifc.disp_req = '0;
  endtask

  task automatic lkp_chk(input int unsigned id0, input int unsigned id1);
    int unsigned ids [2];
    int unsigned ep, es;
    ids[0] = id0; ids[1] = id1;
    @(negedge pclk);
    ifc.lkp_id[0 +: ID_W]    = ID_W'(id0);
    ifc.lkp_id[ID_W +: ID_W] = ID_W'(id1);
    @(negedge pclk);
    for (int c = 0; c < 2; c++) begin
      ep = (ids[c] < m_num) ? m_price[ids[c]] : 0;
      es = (ids[c] < m_num) ? m_stock[ids[c]] : 0;
      chk("lkp_price", 32'(ifc.lkp_price[c*PRICE_W +: PRICE_W]), ep);
      chk("lkp_stock", 32'(ifc.lkp_stock[c*STOCK_W +: STOCK_W]), es);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    disp_exp_t e;
    logic [31:0] d;
    int unsigned op, c;

    ifc.paddr = '0; ifc.psel = 1'b0; ifc.penable = 1'b0; ifc.pwrite = 1'b0; ifc.pwdata = '0;
    ifc.disp_req = '0; ifc.disp_id = '0; ifc.disp_qty = '0; ifc.lkp_id = '0;
    m_reset();
    repeat (3) @(negedge pclk);
    prstn = 1'b1;
    @(negedge pclk);

    // Reset state
    chk("rst_pready",    32'(ifc.pready),    32'd0);
    chk("rst_pslverr",   32'(ifc.pslverr),   32'd0);
    chk("rst_prdata",    ifc.prdata,         32'd0);
    chk("rst_disp_ack",  32'(ifc.disp_ack),  32'd0);
    chk("rst_disp_ok",   32'(ifc.disp_ok),   32'd0);
    chk("rst_lkp_price", ifc.lkp_price,      32'd0);
    chk("rst_lkp_stock", 32'(ifc.lkp_stock), 32'd0);
    apb_xfer(1'b0, 32'h000, 32'h0);

    // Configuration, lock gating, bad address
    apb_xfer(1'b1, 32'h000, 32'h8000_0004);
    apb_xfer(1'b1, 32'h108, 32'h0005_0019);
    apb_xfer(1'b0, 32'h108, 32'h0);
    apb_xfer(1'b1, 32'h000, 32'h0000_0004);
    apb_xfer(1'b1, 32'h108, 32'h0009_0001);
    apb_xfer(1'b0, 32'h108, 32'h0);
    apb_xfer(1'b0, 32'h400, 32'h0);

    // Successful dispense and lookup
    disp_one(0, 2, 3);
    apb_xfer(1'b0, 32'h108, 32'h0);
    apb_xfer(1'b0, 32'h004, 32'h0);
    lkp_chk(0, 2);

    // Failing dispenses and sticky error
    disp_one(0, 2, 3);
    apb_xfer(1'b0, 32'h108, 32'h0);
    apb_xfer(1'b0, 32'h004, 32'h0);
    apb_xfer(1'b1, 32'h004, 32'h0001_0000);
    apb_xfer(1'b0, 32'h004, 32'h0);
    disp_one(0, 2, 0);
    disp_one(1, 5, 1);
    apb_xfer(1'b0, 32'h004, 32'h0);

    // Simultaneous requests
    disp_two(2, 1, 2, 1);
    apb_xfer(1'b0, 32'h108, 32'h0);
    lkp_chk(2, 9);

    // Request held while locked, released by unlocking
    apb_xfer(1'b1, 32'h000, 32'h8000_0004);
    apb_xfer(1'b1, 32'h108, 32'h0003_0019);
    @(negedge pclk);
    set_ch(1, 2, 1);
    ifc.disp_req[1] = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge pclk);
      if (ifc.disp_ack[1]) acks++;
    end
    chk("locked_no_ack", 32'(acks), 32'd0);
    apb_xfer(1'b1, 32'h000, 32'h0000_0004);
    e.ch = 1; e.ok = m_disp(2, 1); disp_q.push_back(e);
    wait_ack(1, 1);
    apb_xfer(1'b0, 32'h108, 32'h0);

    // Reset while a request is pending
    apb_xfer(1'b1, 32'h000, 32'h8000_0004);
    @(negedge pclk);
    set_ch(0, 2, 1);
    ifc.disp_req[0] = 1'b1;
    repeat (3) @(negedge pclk);
    prstn = 1'b0;
    m_reset();
    repeat (2) @(negedge pclk);
    ifc.disp_req = '0;
    prstn = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge pclk);
      if (ifc.disp_ack != '0) acks++;
    end
    chk("reset_no_ack", 32'(acks), 32'd0);
    apb_xfer(1'b0, 32'h108, 32'h0);
    apb_xfer(1'b0, 32'h000, 32'h0);
    apb_xfer(1'b0, 32'h004, 32'h0);

    // Randomized traffic against the model
    repeat (250) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          d = $urandom;
          d[23:16] = 8'($urandom_range(0, 8));
          apb_xfer(1'b1, 32'h100 + 4 * $urandom_range(0, 9), d);
        end
        1: begin
          d = $urandom;
          d[ID_W-1:0] = ID_W'($urandom_range(0, 12));
          apb_xfer(1'b1, 32'h000, d);
        end
        2: begin
          case ($urandom_range(0, 3))
            0: apb_xfer(1'b0, 32'h000, 32'h0);
            1: apb_xfer(1'b0, 32'h004, 32'h0);
            2: apb_xfer(1'b0, 32'h100 + 4 * $urandom_range(0, 12), 32'h0);
            default: apb_xfer(1'b0, 4 * $urandom_range(0, 1023), 32'h0);
          endcase
        end
        3: begin
          d = $urandom;
          apb_xfer(1'b1, 32'h004, d);
        end
        4, 6: begin
          if (m_lock) apb_xfer(1'b1, 32'h000, m_num);
          if (op == 4) begin
            c = $urandom_range(0, NUM_CH - 1);
            disp_one(int'(c), $urandom_range(0, 9), $urandom_range(0, 4));
          end else begin
            disp_two($urandom_range(0, 9), $urandom_range(0, 4),
                     $urandom_range(0, 9), $urandom_range(0, 4));
          end
        end
        default: lkp_chk($urandom_range(0, 12), $urandom_range(0, 12));
      endcase
    end
    apb_xfer(1'b0, 32'h004, 32'h0);

    repeat (4) @(negedge pclk);
    chk("apb_queue_drained",  32'(apb_q.size()),  32'd0);
    chk("disp_queue_drained", 32'(disp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
